// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// Module : ahb_pkg
// Brief  : Shared AHB-Lite encodings and the burst next-address function.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package ahb_pkg;

    typedef logic [1:0] htrans_t;
    typedef logic [2:0] hburst_t;
    typedef logic [2:0] hsize_t;

    localparam htrans_t HTRANS_IDLE   = 2'b00;
    localparam htrans_t HTRANS_BUSY   = 2'b01;
    localparam htrans_t HTRANS_NONSEQ = 2'b10;
    localparam htrans_t HTRANS_SEQ    = 2'b11;

    localparam hburst_t HBURST_SINGLE = 3'b000;
    localparam hburst_t HBURST_INCR   = 3'b001;
    localparam hburst_t HBURST_WRAP4  = 3'b010;
    localparam hburst_t HBURST_INCR4  = 3'b011;
    localparam hburst_t HBURST_WRAP8  = 3'b100;
    localparam hburst_t HBURST_INCR8  = 3'b101;
    localparam hburst_t HBURST_WRAP16 = 3'b110;
    localparam hburst_t HBURST_INCR16 = 3'b111;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int NUM_MEM = 3;

    // Wrapping bursts stay inside an aligned window of beats*(1<<size) bytes.
    function automatic logic [31:0] ahb_next_addr(input logic [31:0] addr,
                                                  input hsize_t      size,
                                                  input hburst_t     burst);
        logic [31:0] inc;
        logic [31:0] mask;
        logic [31:0] result;
        inc    = 32'd1 << size;
        mask   = '0;
        result = addr + inc;
        case (burst)
            HBURST_SINGLE: result = addr;
            HBURST_WRAP4:  mask = (inc << 2) - 32'd1;
            HBURST_WRAP8:  mask = (inc << 3) - 32'd1;
            HBURST_WRAP16: mask = (inc << 4) - 32'd1;
            default:       mask = '0;
        endcase
        if (mask != '0) begin
            result = (addr & ~mask) | ((addr + inc) & mask);
        end
        return result;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ahb_master.sv
// ---------------------------------------------------------------------------
// Module : ahb_master
// Brief  : Command-port AHB-Lite master: address-phase capture, burst address
//          generation, write-data pipelining and read-data capture.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_master
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_hwdata,
    input  logic [ADDR_W-1:0] in_haddr,
    input  logic [2:0]        in_hsize,
    input  logic [2:0]        in_hburst,
    input  logic [1:0]        in_hsel,
    input  logic              in_hwrite,
    input  logic [1:0]        in_htrans,
    input  logic [DATA_W-1:0] hrdata,
    input  logic              hresp,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [1:0]        hsel,
    output logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] out_hrdata
);

    logic [ADDR_W-1:0] haddr_q, haddr_d;
    logic [1:0]        htrans_q, htrans_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [2:0]        hburst_q, hburst_d;
    logic [1:0]        hsel_q, hsel_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] hwdata_q, hwdata_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic              in_burst_q, in_burst_d;
    logic              dvalid_q, dvalid_d;
    logic              dwrite_q, dwrite_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              start;

    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] a,
                                                  input logic [2:0]        s,
                                                  input logic [2:0]        b);
        return ADDR_W'(ahb_next_addr(32'(a), s, b));
    endfunction

    always_comb begin
        start        = 1'b0;
        haddr_d      = haddr_q;
        htrans_d     = HTRANS_IDLE;
        hwrite_d     = hwrite_q;
        hsize_d      = hsize_q;
        hburst_d     = hburst_q;
        hsel_d       = hsel_q;
        wdata_d      = wdata_q;
        burst_addr_d = burst_addr_q;
        in_burst_d   = in_burst_q;
        hwdata_d     = wdata_q;
        dvalid_d     = (htrans_q == HTRANS_NONSEQ) || (htrans_q == HTRANS_SEQ);
        dwrite_d     = hwrite_q;
        rdata_d      = rdata_q;

        if (dvalid_q && !dwrite_q) begin
            rdata_d = (hresp == HRESP_ERROR) ? '0 : hrdata;
        end

        if (enable) begin
            case (in_htrans)
                HTRANS_NONSEQ: start = 1'b1;
                HTRANS_SEQ: begin
                    // A SEQ with no burst in progress has no base address to continue from.
                    if (in_burst_q) begin
                        htrans_d     = HTRANS_SEQ;
                        haddr_d      = burst_addr_q;
                        burst_addr_d = advance(burst_addr_q, hsize_q, hburst_q);
                        wdata_d      = in_hwdata;
                    end else begin
                        start = 1'b1;
                    end
                end
                HTRANS_BUSY: begin
                    if (in_burst_q) begin
                        htrans_d = HTRANS_BUSY;
                    end
                end
                default: in_burst_d = 1'b0;
            endcase
        end else begin
            in_burst_d = 1'b0;
        end

        if (start) begin
            htrans_d     = HTRANS_NONSEQ;
            haddr_d      = in_haddr;
            hwrite_d     = in_hwrite;
            hsize_d      = in_hsize;
            hburst_d     = in_hburst;
            hsel_d       = in_hsel;
            wdata_d      = in_hwdata;
            burst_addr_d = advance(in_haddr, in_hsize, in_hburst);
            in_burst_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            haddr_q      <= '0;
            htrans_q     <= HTRANS_IDLE;
            hwrite_q     <= 1'b0;
            hsize_q      <= '0;
            hburst_q     <= '0;
            hsel_q       <= '0;
            wdata_q      <= '0;
            hwdata_q     <= '0;
            burst_addr_q <= '0;
            in_burst_q   <= 1'b0;
            dvalid_q     <= 1'b0;
            dwrite_q     <= 1'b0;
            rdata_q      <= '0;
        end else begin
            haddr_q      <= haddr_d;
            htrans_q     <= htrans_d;
            hwrite_q     <= hwrite_d;
            hsize_q      <= hsize_d;
            hburst_q     <= hburst_d;
            hsel_q       <= hsel_d;
            wdata_q      <= wdata_d;
            hwdata_q     <= hwdata_d;
            burst_addr_q <= burst_addr_d;
            in_burst_q   <= in_burst_d;
            dvalid_q     <= dvalid_d;
            dwrite_q     <= dwrite_d;
            rdata_q      <= rdata_d;
        end
    end

    assign haddr      = haddr_q;
    assign htrans     = htrans_q;
    assign hwrite     = hwrite_q;
    assign hsel       = hsel_q;
    assign hwdata     = hwdata_q;
    assign out_hrdata = rdata_q;

endmodule

`default_nettype wire

// File: rtl/ahb_mem_slave.sv
// ---------------------------------------------------------------------------
// Module : ahb_mem_slave
// Brief  : Zero-wait AHB-Lite word memory; storage is not cleared by reset.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_mem_slave
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [IDX_W-1:0]  haddr,
    input  logic [DATA_W-1:0] hwdata,
    output logic [DATA_W-1:0] hrdata,
    output logic              hresp
);

    logic              valid_q, valid_d;
    logic              write_q, write_d;
    logic [IDX_W-1:0]  addr_q, addr_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_comb begin
        valid_d = hsel && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
        write_d = valid_d ? hwrite : write_q;
        addr_d  = valid_d ? haddr  : addr_q;
        mem_we  = valid_q && write_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            valid_q <= valid_d;
            write_q <= write_d;
            addr_q  <= addr_d;
        end
    end

    // Whole word written regardless of transfer size.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= hwdata;
        end
    end

    assign hrdata = mem_q[addr_q];
    assign hresp  = HRESP_OKAY;

endmodule

`default_nettype wire

// File: rtl/ahb_top.sv
// ---------------------------------------------------------------------------
// Module : ahb_top
// Brief  : AHB-Lite subsystem: command master, decoder, three memory slaves,
//          default error slave and data-phase response mux.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_top
    import ahb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 16
) (
    input  logic              clk,
    input  logic              hresetn,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_hwdata,
    input  logic [ADDR_W-1:0] in_haddr,
    input  logic [2:0]        in_hsize,
    input  logic [2:0]        in_hburst,
    input  logic [1:0]        in_hsel,
    input  logic              in_hwrite,
    input  logic [1:0]        in_htrans,
    output logic [DATA_W-1:0] out_hrdata
);

    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [ADDR_W-1:0] haddr;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [1:0]        hsel;
    logic [DATA_W-1:0] hwdata;
    logic [DATA_W-1:0] hrdata;
    logic              hresp;
    logic [3:0]        hsel_x;
    logic [3:0]        dsel_q, dsel_d;
    logic              err_valid_q, err_valid_d;
    logic [DATA_W-1:0] mem_rdata [NUM_MEM];
    logic              mem_resp  [NUM_MEM];
    logic              unused_haddr_hi;

    ahb_master #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_master (
        .clk        (clk),
        .rst        (hresetn),
        .enable     (enable),
        .in_hwdata  (in_hwdata),
        .in_haddr   (in_haddr),
        .in_hsize   (in_hsize),
        .in_hburst  (in_hburst),
        .in_hsel    (in_hsel),
        .in_hwrite  (in_hwrite),
        .in_htrans  (in_htrans),
        .hrdata     (hrdata),
        .hresp      (hresp),
        .haddr      (haddr),
        .htrans     (htrans),
        .hwrite     (hwrite),
        .hsel       (hsel),
        .hwdata     (hwdata),
        .out_hrdata (out_hrdata)
    );

    // Any select value outside 0..2, including unknown, lands on the error slave.
    always_comb begin
        hsel_x = '0;
        case (hsel)
            2'd0:    hsel_x[0] = 1'b1;
            2'd1:    hsel_x[1] = 1'b1;
            2'd2:    hsel_x[2] = 1'b1;
            default: hsel_x[3] = 1'b1;
        endcase
    end

    for (genvar i = 0; i < NUM_MEM; i++) begin : g_mem
        ahb_mem_slave #(
            .DATA_W (DATA_W),
            .DEPTH  (MEM_DEPTH),
            .IDX_W  (IDX_W)
        ) u_mem (
            .clk    (clk),
            .rst    (hresetn),
            .hsel   (hsel_x[i]),
            .htrans (htrans),
            .hwrite (hwrite),
            .haddr  (haddr[IDX_W-1:0]),
            .hwdata (hwdata),
            .hrdata (mem_rdata[i]),
            .hresp  (mem_resp[i])
        );
    end

    assign unused_haddr_hi = ^haddr[ADDR_W-1:IDX_W];

    always_comb begin
        dsel_d      = hsel_x;
        err_valid_d = hsel_x[3] && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    end

    always_ff @(posedge clk or posedge hresetn) begin
        if (hresetn) begin
            dsel_q      <= '0;
            err_valid_q <= 1'b0;
        end else begin
            dsel_q      <= dsel_d;
            err_valid_q <= err_valid_d;
        end
    end

    // Response follows the slave that owns the current data phase.
    always_comb begin
        hrdata = '0;
        hresp  = HRESP_OKAY;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (dsel_q[i]) begin
                hrdata = mem_rdata[i];
                hresp  = mem_resp[i];
            end
        end
        if (dsel_q[3]) begin
            hresp = err_valid_q ? HRESP_ERROR : HRESP_OKAY;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ahb_top.sv
// ---------------------------------------------------------------------------
// Module : tb_ahb_top
// Brief  : Directed scoreboard bench for ahb_top bursts, errors and reset.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ahb_top;
    import ahb_pkg::*;

    logic        clk;
    logic        hresetn;
    logic        enable;
    logic [31:0] in_hwdata;
    logic [31:0] in_haddr;
    logic [2:0]  in_hsize;
    logic [2:0]  in_hburst;
    logic [1:0]  in_hsel;
    logic        in_hwrite;
    logic [1:0]  in_htrans;
    logic [31:0] out_hrdata;

    typedef struct {
        int          due;
        bit          is_resp;
        logic [31:0] val;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mem_m [3][16];
    int          ncyc;
    int          checks;
    int          errors;

    ahb_top dut (
        .clk        (clk),
        .hresetn    (hresetn),
        .enable     (enable),
        .in_hwdata  (in_hwdata),
        .in_haddr   (in_haddr),
        .in_hsize   (in_hsize),
        .in_hburst  (in_hburst),
        .in_hsel    (in_hsel),
        .in_hwrite  (in_hwrite),
        .in_htrans  (in_htrans),
        .out_hrdata (out_hrdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(posedge clk);
        #1;
        ncyc++;
        while (sb.size() > 0 && sb[0].due <= ncyc) begin
            e = sb.pop_front();
            if (e.is_resp) chk("hresp", {31'b0, dut.hresp}, e.val);
            else           chk("rdata", out_hrdata, e.val);
        end
    endtask

    task automatic do_reset();
        hresetn = 1'b1;
        sb.delete();
        tick();
        tick();
        hresetn = 1'b0;
    endtask

    task automatic step(input logic en, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic [2:0] bu, input logic [1:0] sl,
                        input logic wr, input logic [31:0] wd,
                        input logic [1:0] exp_tr, input int exp_a);
        sb_t        e;
        logic [3:0] idx;
        enable    = en;
        in_htrans = tr;
        in_haddr  = a;
        in_hsize  = sz;
        in_hburst = bu;
        in_hsel   = sl;
        in_hwrite = wr;
        in_hwdata = wd;
        if (en && (tr == HTRANS_NONSEQ || tr == HTRANS_SEQ) && exp_a >= 0) begin
            idx       = exp_a[3:0];
            e.due     = ncyc + 2;
            e.is_resp = 1'b1;
            e.val     = (sl == 2'd3) ? 32'd1 : 32'd0;
            sb.push_back(e);
            if (wr) begin
                if (sl != 2'd3) mem_m[sl][idx] = wd;
            end else begin
                e.due     = ncyc + 3;
                e.is_resp = 1'b0;
                e.val     = (sl == 2'd3) ? 32'd0 : mem_m[sl][idx];
                sb.push_back(e);
            end
        end
        tick();
        chk("htrans", {30'b0, dut.htrans}, {30'b0, exp_tr});
        if (exp_a >= 0) chk("haddr", dut.haddr, exp_a);
    endtask

    task automatic idle();
        step(1'b0, HTRANS_IDLE, 32'd0, 3'd0, HBURST_SINGLE, 2'd0, 1'b0, 32'd0, HTRANS_IDLE, -1);
    endtask

    initial begin
        ncyc   = 0;
        checks = 0;
        errors = 0;
        enable = 1'b0; in_hwdata = '0; in_haddr = '0; in_hsize = '0;
        in_hburst = '0; in_hsel = '0; in_hwrite = 1'b0; in_htrans = HTRANS_IDLE;

        do_reset();
        chk("reset_rdata", out_hrdata, 32'd0);
        chk("reset_htrans", {30'b0, dut.htrans}, {30'b0, HTRANS_IDLE});

        // enable low with unknown select/trans keeps the bus idle
        step(1'b0, 2'bxx, 32'd0, 3'd0, HBURST_SINGLE, 2'bxx, 1'b0, 32'd0, HTRANS_IDLE, -1);
        step(1'b0, 2'bxx, 32'd0, 3'd0, HBURST_SINGLE, 2'bxx, 1'b1, 32'd0, HTRANS_IDLE, -1);

        // WRAP4 byte writes from address 1 on slave 0
        step(1'b1, HTRANS_NONSEQ, 32'd1, 3'd0, HBURST_WRAP4, 2'd0, 1'b1, 32'd1, HTRANS_NONSEQ, 1);
        step(1'b1, HTRANS_SEQ,    32'd9, 3'd0, HBURST_WRAP4, 2'd0, 1'b1, 32'd2, HTRANS_SEQ,    2);
        step(1'b1, HTRANS_SEQ,    32'd9, 3'd0, HBURST_WRAP4, 2'd0, 1'b1, 32'd3, HTRANS_SEQ,    3);
        step(1'b1, HTRANS_SEQ,    32'd9, 3'd0, HBURST_WRAP4, 2'd0, 1'b1, 32'd4, HTRANS_SEQ,    0);
        idle();

        // WRAP4 read back, continuing past four beats
        step(1'b1, HTRANS_NONSEQ, 32'd1, 3'd0, HBURST_WRAP4, 2'd0, 1'b0, 32'd0, HTRANS_NONSEQ, 1);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_WRAP4, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    2);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_WRAP4, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    3);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_WRAP4, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    0);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_WRAP4, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    1);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_WRAP4, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    2);

        // INCR4 word writes on slave 1, then back-to-back read burst
        step(1'b1, HTRANS_NONSEQ, 32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b1, 32'hAAAA_0001, HTRANS_NONSEQ, 0);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b1, 32'hBBBB_0002, HTRANS_SEQ,    4);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b1, 32'hCCCC_0003, HTRANS_SEQ,    8);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b1, 32'hDDDD_0004, HTRANS_SEQ,    12);
        step(1'b1, HTRANS_NONSEQ, 32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b0, 32'd0, HTRANS_NONSEQ, 0);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b0, 32'd0, HTRANS_SEQ,    4);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b0, 32'd0, HTRANS_SEQ,    8);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd2, HBURST_INCR4, 2'd1, 1'b0, 32'd0, HTRANS_SEQ,    12);

        // write immediately followed by read of the same word
        step(1'b1, HTRANS_NONSEQ, 32'd5, 3'd2, HBURST_SINGLE, 2'd2, 1'b1, 32'h1234_5678, HTRANS_NONSEQ, 5);
        step(1'b1, HTRANS_NONSEQ, 32'd5, 3'd2, HBURST_SINGLE, 2'd2, 1'b0, 32'd0,         HTRANS_NONSEQ, 5);

        // BUSY mid INCR: address held, BUSY data never written
        step(1'b1, HTRANS_NONSEQ, 32'd8, 3'd0, HBURST_INCR, 2'd2, 1'b1, 32'h0000_0011, HTRANS_NONSEQ, 8);
        step(1'b1, HTRANS_BUSY,   32'd0, 3'd0, HBURST_INCR, 2'd2, 1'b1, 32'h0000_0BAD, HTRANS_BUSY,   8);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_INCR, 2'd2, 1'b1, 32'h0000_0022, HTRANS_SEQ,    9);
        step(1'b1, HTRANS_NONSEQ, 32'd8, 3'd0, HBURST_INCR, 2'd2, 1'b0, 32'd0, HTRANS_NONSEQ, 8);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_INCR, 2'd2, 1'b0, 32'd0, HTRANS_SEQ,    9);

        // default slave: error response, zero data, memories untouched
        step(1'b1, HTRANS_NONSEQ, 32'd1, 3'd0, HBURST_SINGLE, 2'd3, 1'b1, 32'hDEAD_BEEF, HTRANS_NONSEQ, 1);
        step(1'b1, HTRANS_NONSEQ, 32'd1, 3'd0, HBURST_SINGLE, 2'd3, 1'b0, 32'd0, HTRANS_NONSEQ, 1);
        step(1'b1, HTRANS_NONSEQ, 32'd1, 3'd0, HBURST_SINGLE, 2'd0, 1'b0, 32'd0, HTRANS_NONSEQ, 1);
        step(1'b1, HTRANS_NONSEQ, 32'd4, 3'd2, HBURST_SINGLE, 2'd1, 1'b0, 32'd0, HTRANS_NONSEQ, 4);
        step(1'b1, HTRANS_NONSEQ, 32'd5, 3'd2, HBURST_SINGLE, 2'd2, 1'b0, 32'd0, HTRANS_NONSEQ, 5);
        idle();
        idle();
        idle();

        // reset in the middle of a read burst, then SEQ must restart as NONSEQ
        step(1'b1, HTRANS_NONSEQ, 32'd0, 3'd0, HBURST_INCR, 2'd0, 1'b0, 32'd0, HTRANS_NONSEQ, 0);
        step(1'b1, HTRANS_SEQ,    32'd0, 3'd0, HBURST_INCR, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    1);
        enable = 1'b0;
        do_reset();
        chk("midreset_rdata", out_hrdata, 32'd0);
        chk("midreset_htrans", {30'b0, dut.htrans}, {30'b0, HTRANS_IDLE});
        step(1'b1, HTRANS_SEQ, 32'd3, 3'd0, HBURST_INCR, 2'd0, 1'b0, 32'd0, HTRANS_NONSEQ, 3);
        step(1'b1, HTRANS_SEQ, 32'd0, 3'd0, HBURST_INCR, 2'd0, 1'b0, 32'd0, HTRANS_SEQ,    4);
        idle();
        idle();
        idle();
        idle();

        chk("sb_drain", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
